// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion. Produces round keys 0..10 on request, 2+ cycles each.
// Optional KEY_SCHED_AUTOWRAP_EN: advance at round 10 reloads the stored cipher key.
module key_schedule #(
  parameter int SBOX_LAT = 1  // S-box pipeline depth, 1..4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         load,
  input  logic         advance,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         last_round
);

  typedef enum logic [1:0] {IDLE, READY, SUB, MIX} state_t;

  state_t      state, state_nx;
  logic [2:0]  sub_cnt;
  logic [7:0]  rcon;
  logic [31:0] sub_p [SBOX_LAT];
  logic [31:0] sub_word;
  logic [31:0] w0, w1, w2, w3, rot_w3;
  logic [31:0] w0_nx, w1_nx, w2_nx, w3_nx;
  logic        do_adv, do_commit;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 (0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word_f(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign w0     = round_key[127:96];
  assign w1     = round_key[95:64];
  assign w2     = round_key[63:32];
  assign w3     = round_key[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  assign sub_word = sub_p[SBOX_LAT-1];
  assign w0_nx    = w0 ^ sub_word ^ {rcon, 24'h0};
  assign w1_nx    = w1 ^ w0_nx;
  assign w2_nx    = w2 ^ w1_nx;
  assign w3_nx    = w3 ^ w2_nx;

  assign do_adv    = (state == READY) && advance && (round_idx != 4'd10);
  assign do_commit = (state == MIX) && !load;

  assign key_valid  = (state == READY);
  assign busy       = (state == SUB) || (state == MIX);
  assign last_round = key_valid && (round_idx == 4'd10);

  // S-box stages: free-running, round_key is frozen for the whole SUB window
  always_ff @(posedge clk) begin
    sub_p[0] <= sub_word_f(rot_w3);
    for (int i = 1; i < SBOX_LAT; i++) sub_p[i] <= sub_p[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = READY;
    end else begin
      case (state)
        READY:   if (do_adv) state_nx = SUB;
        SUB:     if (sub_cnt == 3'(SBOX_LAT - 1)) state_nx = MIX;
        MIX:     state_nx = READY;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sub_cnt <= 3'd0;
    else     sub_cnt <= (state == SUB) ? sub_cnt + 3'd1 : 3'd0;
  end

`ifdef KEY_SCHED_AUTOWRAP_EN
  logic [127:0] cipher_key;
  logic         do_wrap;

  assign do_wrap = (state == READY) && advance && (round_idx == 4'd10) && !load;

  always_ff @(posedge clk) begin
    if (load) cipher_key <= key;
  end
`endif

  // Commit stage: round key, index and rcon move together
  always_ff @(posedge clk) begin
    if (rst) begin
      round_key <= 128'h0;
      round_idx <= 4'd0;
      rcon      <= 8'h01;
    end else if (load) begin
      round_key <= key;
      round_idx <= 4'd0;
      rcon      <= 8'h01;
    end else if (do_commit) begin
      round_key <= {w0_nx, w1_nx, w2_nx, w3_nx};
      round_idx <= round_idx + 4'd1;
      rcon      <= xtime(rcon);
`ifdef KEY_SCHED_AUTOWRAP_EN
    end else if (do_wrap) begin
      round_key <= cipher_key;
      round_idx <= 4'd0;
      rcon      <= 8'h01;
`endif
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: FIPS-197 key expansion model plus directed control scenarios.
module tb_key_schedule #(
  parameter int SBOX_LAT = 1
);

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_R10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10= 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst, load, advance;
  logic [127:0] key;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid, busy, last_round;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  key_schedule #(.SBOX_LAT(SBOX_LAT)) dut (
    .clk(clk), .rst(rst), .key(key), .load(load), .advance(advance),
    .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
    .busy(busy), .last_round(last_round)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX_HEX[2047 - 8*int'(b) -: 8];
  endfunction

  // Straight FIPS-197 word expansion into all eleven round keys.
  function automatic logic [0:10][127:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [0:10][127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {RCON[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 11; n++) r[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    return r;
  endfunction

  // Reference: a loaded key set, an index, and a countdown of cycles until the next key
  logic [0:10][127:0] m_keys;
  bit   m_loaded = 1'b0;
  int   m_idx = 0;
  int   m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_loaded <= 1'b0;
      m_idx    <= 0;
      m_cnt    <= 0;
    end else if (load) begin
      m_keys   <= expand(key);
      m_loaded <= 1'b1;
      m_idx    <= 0;
      m_cnt    <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_idx <= m_idx + 1;
    end else if (m_loaded && advance) begin
      if (m_idx < 10) m_cnt <= SBOX_LAT + 1;
`ifdef KEY_SCHED_AUTOWRAP_EN
      else m_idx <= 0;
`endif
    end
  end

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [127:0] e_key;
      logic         e_valid;
      e_key   = m_loaded ? m_keys[m_idx] : 128'h0;
      e_valid = m_loaded && (m_cnt == 0);
      chk("cycle {key,idx,valid,busy,last}",
          {round_key, round_idx, key_valid, busy, last_round},
          {e_key, 4'(m_idx), e_valid, (m_cnt != 0), e_valid && (m_idx == 10)});
    end
  end

  task automatic pulse_adv();
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
  endtask

  task automatic pulse_load(input logic [127:0] k);
    key  = k;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic adv_measure(output int low);
    pulse_adv();
    low = 0;
    while (!key_valid && low < 50) begin
      low++;
      @(negedge clk);
    end
    chk("latency", low, SBOX_LAT + 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!key_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", key_valid, 1);
  endtask

  initial begin
    int low;
    rst = 1'b1; load = 1'b0; advance = 1'b0; key = 128'h0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset state", {round_key, round_idx, key_valid, busy, last_round}, 136'h0);
    rst = 1'b0;

    pulse_load(K1);
    chk("load K1", {round_key, round_idx, key_valid, busy}, {K1, 4'd0, 1'b1, 1'b0});
    chk("model K1 round1", m_keys[1], K1_R1);
    chk("model K1 round10", m_keys[10], K1_R10);

    adv_measure(low);
    chk("round1", {round_key, round_idx}, {K1_R1, 4'd1});
    adv_measure(low);
    chk("round2", {round_key, round_idx}, {K1_R2, 4'd2});
    for (int r = 3; r <= 10; r++) begin
      adv_measure(low);
      chk("round idx", round_idx, r);
    end
    chk("round10", {round_key, round_idx, last_round}, {K1_R10, 4'd10, 1'b1});

    pulse_adv();
    @(negedge clk);
`ifdef KEY_SCHED_AUTOWRAP_EN
    chk("wrap to round0", {round_key, round_idx, key_valid, busy}, {K1, 4'd0, 1'b1, 1'b0});
`else
    chk("advance at 10 ignored", {round_key, round_idx, last_round}, {K1_R10, 4'd10, 1'b1});
`endif

    // Advance while busy must not start a second expansion
    pulse_load(K1);
    pulse_adv();
    pulse_adv();
    wait_valid();
    repeat (SBOX_LAT + 3) @(negedge clk);
    chk("busy advance ignored", {round_key, round_idx, key_valid}, {K1_R1, 4'd1, 1'b1});

    key = K2; load = 1'b1; advance = 1'b1;
    @(negedge clk);
    load = 1'b0; advance = 1'b0;
    chk("load wins", {round_key, round_idx, key_valid}, {K2, 4'd0, 1'b1});
    repeat (3) @(negedge clk);
    chk("load wins, no expansion", {round_idx, key_valid, busy}, {4'd0, 1'b1, 1'b0});
    chk("model K2 round10", m_keys[10], K2_R10);

    // Load during SUB aborts the in-flight round
    pulse_adv();
    chk("in SUB", {key_valid, busy}, {1'b0, 1'b1});
    pulse_load(K1);
    chk("load in SUB", {round_key, round_idx, key_valid}, {K1, 4'd0, 1'b1});
    repeat (SBOX_LAT + 2) @(negedge clk);
    chk("no late commit", {round_key, round_idx}, {K1, 4'd0});

    // Reset during MIX
    pulse_adv();
    repeat (SBOX_LAT) @(negedge clk);
    chk("in MIX", {key_valid, busy}, {1'b0, 1'b1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst in MIX", {round_key, round_idx, key_valid, busy, last_round}, 136'h0);
    pulse_adv();
    @(negedge clk);
    chk("advance in IDLE ignored", {round_key, round_idx, key_valid, busy}, 136'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
